// File: rtl/mem_stage_access.sv
// MEM pipeline stage: drives a req/ack data-memory handshake and stalls the
// pipeline while an access is outstanding. Also holds the MEM/WB register.
module mem_stage_access (
    input  logic        clk,
    input  logic        R,
    input  logic        E_mem,
    input  logic        rw_dm_mem,
    input  logic [1:0]  size_mem,
    input  logic        se_mem,
    input  logic [31:0] alu_out_mem,
    input  logic [31:0] store_data_mem,
    input  logic [31:0] PC_D_mem,
    input  logic [31:0] mem_sethi_imm22,
    input  logic [1:0]  load_mem,
    input  logic        rf_le_mem,
    input  logic [4:0]  mem_rd,
    output logic        dm_req,
    output logic        dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    output logic [3:0]  dm_be,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ack,
    output logic        mem_stall,
    output logic [31:0] mem_fwd_data,
    output logic        align_err,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_rf_le
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      state, state_nxt;
    logic        aligned, latch_hold;
    logic [3:0]  be_calc;
    logic [31:0] wdata_calc;

    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_be;
    logic        hold_we, hold_se, hold_rf_le;
    logic [1:0]  hold_size;
    logic [4:0]  hold_rd;

    logic [1:0]  ext_offs, ext_size;
    logic        ext_se;
    logic [31:0] load_data, mux_val;
    logic [31:0] wb_data_nxt;
    logic [4:0]  wb_rd_nxt;
    logic        wb_rf_le_nxt;

    // Big-endian lanes: offset 0 is the most significant byte of the word.
    function automatic logic [31:0] extract_load(input logic [31:0] rdata,
                                                 input logic [1:0]  offs,
                                                 input logic [1:0]  size,
                                                 input logic        se);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (offs)
            2'b00:   b = rdata[31:24];
            2'b01:   b = rdata[23:16];
            2'b10:   b = rdata[15:8];
            default: b = rdata[7:0];
        endcase
        h = offs[1] ? rdata[15:0] : rdata[31:16];
        case (size)
            2'b00:   r = {{24{se & b[7]}}, b};
            2'b01:   r = {{16{se & h[15]}}, h};
            default: r = rdata;
        endcase
        return r;
    endfunction

    always_comb begin
        aligned    = 1'b1;
        be_calc    = 4'b1111;
        wdata_calc = store_data_mem;
        case (size_mem)
            2'b00: begin
                be_calc    = 4'b1000 >> alu_out_mem[1:0];
                wdata_calc = {4{store_data_mem[7:0]}};
            end
            2'b01: begin
                aligned    = ~alu_out_mem[0];
                be_calc    = alu_out_mem[1] ? 4'b0011 : 4'b1100;
                wdata_calc = {2{store_data_mem[15:0]}};
            end
            default: aligned = (alu_out_mem[1:0] == 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) state <= IDLE;
        else    state <= state_nxt;
    end

    // Stall and alignment outputs are forced low while reset is held.
    always_comb begin
        state_nxt  = state;
        dm_req     = 1'b0;
        mem_stall  = 1'b0;
        align_err  = 1'b0;
        latch_hold = 1'b0;
        case (state)
            IDLE: begin
                if (E_mem) begin
                    if (aligned) begin
                        mem_stall  = 1'b1;
                        latch_hold = 1'b1;
                        state_nxt  = WAIT;
                    end else begin
                        align_err = 1'b1;
                    end
                end
            end
            WAIT: begin
                dm_req    = 1'b1;
                mem_stall = ~dm_ack;
                if (dm_ack) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (!R) begin
            mem_stall = 1'b0;
            align_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_be    <= '0;
            hold_we    <= 1'b0;
            hold_size  <= '0;
            hold_se    <= 1'b0;
            hold_rd    <= '0;
            hold_rf_le <= 1'b0;
        end else if (latch_hold) begin
            hold_addr  <= alu_out_mem;
            hold_wdata <= wdata_calc;
            hold_be    <= be_calc;
            hold_we    <= rw_dm_mem;
            hold_size  <= size_mem;
            hold_se    <= se_mem;
            hold_rd    <= mem_rd;
            hold_rf_le <= rf_le_mem;
        end
    end

    assign dm_addr  = hold_addr;
    assign dm_wdata = hold_wdata;
    assign dm_we    = (state == WAIT) & hold_we;
    assign dm_be    = (state == WAIT) ? hold_be : 4'b0000;

    always_comb begin
        ext_offs = (state == WAIT) ? hold_addr[1:0] : alu_out_mem[1:0];
        ext_size = (state == WAIT) ? hold_size : size_mem;
        ext_se   = (state == WAIT) ? hold_se : se_mem;
        load_data = extract_load(dm_rdata, ext_offs, ext_size, ext_se);
        case (load_mem)
            2'b00:   mux_val = alu_out_mem;
            2'b01:   mux_val = load_data;
            2'b10:   mux_val = PC_D_mem;
            default: mux_val = mem_sethi_imm22;
        endcase
    end

    assign mem_fwd_data = mux_val;

    // Anything other than a retiring instruction writes a bubble into MEM/WB.
    always_comb begin
        wb_data_nxt  = '0;
        wb_rd_nxt    = '0;
        wb_rf_le_nxt = 1'b0;
        if (state == IDLE && !E_mem) begin
            wb_data_nxt  = mux_val;
            wb_rd_nxt    = mem_rd;
            wb_rf_le_nxt = rf_le_mem;
        end else if (state == WAIT && dm_ack) begin
            wb_data_nxt  = mux_val;
            wb_rd_nxt    = hold_rd;
            wb_rf_le_nxt = hold_rf_le & ~hold_we;
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            wb_data  <= '0;
            wb_rd    <= '0;
            wb_rf_le <= 1'b0;
        end else begin
            wb_data  <= wb_data_nxt;
            wb_rd    <= wb_rd_nxt;
            wb_rf_le <= wb_rf_le_nxt;
        end
    end

endmodule

// File: tb/tb_mem_stage_access.sv
// Bench for mem_stage_access: directed and random instructions checked against a
// transaction-level model of lanes, handshake timing and writeback.
module tb_mem_stage_access;

    logic        clk = 1'b0;
    logic        R;
    logic        E_mem, rw_dm_mem, se_mem, rf_le_mem;
    logic [1:0]  size_mem, load_mem;
    logic [31:0] alu_out_mem, store_data_mem, PC_D_mem, mem_sethi_imm22;
    logic [4:0]  mem_rd;
    logic        dm_req, dm_we, dm_ack;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_stall, align_err, wb_rf_le;
    logic [31:0] mem_fwd_data, wb_data;
    logic [4:0]  wb_rd;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    mem_stage_access dut (
        .clk(clk), .R(R), .E_mem(E_mem), .rw_dm_mem(rw_dm_mem), .size_mem(size_mem),
        .se_mem(se_mem), .alu_out_mem(alu_out_mem), .store_data_mem(store_data_mem),
        .PC_D_mem(PC_D_mem), .mem_sethi_imm22(mem_sethi_imm22), .load_mem(load_mem),
        .rf_le_mem(rf_le_mem), .mem_rd(mem_rd), .dm_req(dm_req), .dm_we(dm_we),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_be(dm_be), .dm_rdata(dm_rdata),
        .dm_ack(dm_ack), .mem_stall(mem_stall), .mem_fwd_data(mem_fwd_data),
        .align_err(align_err), .wb_data(wb_data), .wb_rd(wb_rd), .wb_rf_le(wb_rf_le)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned nBytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] rdata, input logic [31:0] addr,
                                              input logic [1:0] sz, input logic se);
        int unsigned n = nBytes(sz);
        int unsigned shift = (4 - addr % 4 - n) * 8;
        logic [31:0] mask;
        logic [31:0] raw;
        raw = rdata >> shift;
        if (n < 4) begin
            mask = (32'h1 << (8 * n)) - 1;
            raw  = raw & mask;
            if (se && raw[8 * n - 1]) raw = raw | ~mask;
        end
        return raw;
    endfunction

    function automatic logic [3:0] modelBe(input logic [31:0] addr, input logic [1:0] sz);
        int unsigned n = nBytes(sz);
        int unsigned lanes = ((1 << n) - 1) << (4 - addr % 4 - n);
        return 4'(lanes);
    endfunction

    function automatic logic [31:0] modelWdata(input logic [31:0] sd, input logic [1:0] sz);
        logic [31:0] b = {24'h0, sd[7:0]};
        logic [31:0] h = {16'h0, sd[15:0]};
        int unsigned n = nBytes(sz);
        return (n == 1) ? b * 32'h01010101 : (n == 2) ? h * 32'h00010001 : sd;
    endfunction

    // Drives one instruction into MEM, plays the memory side, checks until it retires.
    task automatic applyStimulus(input logic e, input logic rw, input logic [1:0] sz,
                                 input logic se, input logic [31:0] addr, input logic [31:0] sd,
                                 input logic [31:0] pcd, input logic [31:0] sethi,
                                 input logic [1:0] lsel, input logic rfle, input logic [4:0] rd,
                                 input logic [31:0] rdata, input int delay);
        int unsigned n;
        logic valid, misal, done;
        logic [31:0] expWb, expData;
        logic [4:0] expRd;
        logic expLe;
        int cycle, stalls, waitK;
        E_mem = e; rw_dm_mem = rw; size_mem = sz; se_mem = se; alu_out_mem = addr;
        store_data_mem = sd; PC_D_mem = pcd; mem_sethi_imm22 = sethi; load_mem = lsel;
        rf_le_mem = rfle; mem_rd = rd; dm_rdata = rdata;
        dm_ack = e ? 1'b0 : 1'($urandom_range(0, 1));
        n = nBytes(sz);
        valid = e && (addr % n == 0);
        misal = e && (addr % n != 0);
        case (lsel)
            2'b00:   expWb = addr;
            2'b01:   expWb = modelLoad(rdata, addr, sz, se);
            2'b10:   expWb = pcd;
            default: expWb = sethi;
        endcase
        expData = misal ? 32'h0 : expWb;
        expRd   = misal ? 5'd0 : rd;
        expLe   = !misal && !(e && rw) && rfle;
        cycle = 0; stalls = 0; waitK = 0; done = 1'b0;
        while (!done && cycle < 40) begin
            @(negedge clk);
            if (cycle == 0) begin
                checkOutput("stall_issue", mem_stall, valid);
                checkOutput("align_err", align_err, misal);
                checkOutput("req_issue", dm_req, 0);
            end else begin
                checkOutput("bubble_le", wb_rf_le, 0);
                checkOutput("bubble_rd", wb_rd, 0);
            end
            if (dm_req) begin
                waitK++;
                if (waitK == 1) begin
                    checkOutput("dm_addr", dm_addr, addr);
                    checkOutput("dm_be", dm_be, modelBe(addr, sz));
                    checkOutput("dm_we", dm_we, rw);
                    checkOutput("dm_wdata", dm_wdata, modelWdata(sd, sz));
                end else begin
                    checkOutput("addr_hold", dm_addr, addr);
                end
                if (waitK == delay + 1) dm_ack = 1'b1;
            end
            #1;
            if (!mem_stall) done = 1'b1;
            else stalls++;
            cycle++;
            if (done && (!e || (valid && !rw))) checkOutput("fwd", mem_fwd_data, expWb);
        end
        if (!done) checkOutput("timeout", mem_stall, 0);
        checkOutput("stall_cycles", stalls, valid ? 1 + delay : 0);
        @(posedge clk);
        #1;
        dm_ack = 1'b0;
        checkOutput("wb_rf_le", wb_rf_le, expLe);
        if (!(e && rw)) begin
            checkOutput("wb_data", wb_data, expData);
            checkOutput("wb_rd", wb_rd, expRd);
        end
        checkOutput("req_after", dm_req, 0);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        R = 1'b0; E_mem = 1'b1; rw_dm_mem = 1'b0; size_mem = 2'b10; se_mem = 1'b0;
        alu_out_mem = 32'h0; store_data_mem = 32'hA5A5A5A5; PC_D_mem = 32'h0;
        mem_sethi_imm22 = 32'h0; load_mem = 2'b01; rf_le_mem = 1'b1; mem_rd = 5'd1;
        dm_rdata = 32'h0; dm_ack = 1'b0;
        #3;
        checkOutput("rst_stall", mem_stall, 0);
        checkOutput("rst_req", dm_req, 0);
        checkOutput("rst_be", dm_be, 0);
        checkOutput("rst_addr", dm_addr, 0);
        checkOutput("rst_wb_data", wb_data, 0);
        checkOutput("rst_wb_le", wb_rf_le, 0);
        checkOutput("rst_align", align_err, 0);
        E_mem = 1'b0;
        #2 R = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 2'b00, 0, 32'h12345678, 0, 32'h0, 32'h0, 2'b00, 1, 5'd5, 32'h0, 0);
        applyStimulus(1, 0, 2'b00, 1, 32'h101, 0, 32'h0, 32'h0, 2'b01, 1, 5'd7, 32'h11F02233, 2);
        applyStimulus(1, 1, 2'b01, 0, 32'h202, 32'h0000BEEF, 32'h0, 32'h0, 2'b00, 1, 5'd9, 32'h0, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h103, 0, 32'h0, 32'h0, 2'b01, 1, 5'd3, 32'hDEADBEEF, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h0, 0, 32'h0, 32'h0, 2'b01, 1, 5'd10, 32'hCAFEF00D, 0);
        applyStimulus(1, 0, 2'b10, 0, 32'h4, 0, 32'h0, 32'h0, 2'b01, 1, 5'd11, 32'h0BADC0DE, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 0, 32'h00400010, 32'h0, 2'b10, 1, 5'd15, 32'h0, 0);
        applyStimulus(0, 0, 2'b00, 0, 32'h0, 0, 32'h0, 32'hABCDE000, 2'b11, 1, 5'd16, 32'h0, 0);

        // Reset in the middle of an outstanding access, then a late ack.
        E_mem = 1'b1; rw_dm_mem = 1'b0; size_mem = 2'b10; alu_out_mem = 32'h40; load_mem = 2'b01;
        rf_le_mem = 1'b1; mem_rd = 5'd20; dm_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("mid_req_before", dm_req, 1);
        #1 R = 1'b0;
        #1;
        checkOutput("mid_req", dm_req, 0);
        checkOutput("mid_wb_data", wb_data, 0);
        checkOutput("mid_wb_rd", wb_rd, 0);
        checkOutput("mid_wb_le", wb_rf_le, 0);
        checkOutput("mid_stall", mem_stall, 0);
        E_mem = 1'b0; rf_le_mem = 1'b0; load_mem = 2'b00;
        #1 R = 1'b1;
        dm_ack = 1'b1;
        #1;
        checkOutput("late_ack_stall", mem_stall, 0);
        checkOutput("late_ack_req", dm_req, 0);
        @(posedge clk);
        #1;
        checkOutput("late_ack_wb_le", wb_rf_le, 0);
        dm_ack = 1'b0;

        for (int i = 0; i < 80; i++) begin
            int kind = $urandom_range(0, 3);
            logic [1:0] sz = 2'($urandom_range(0, 3));
            logic [31:0] a = $urandom;
            logic rw = 1'($urandom_range(0, 1));
            logic [1:0] lsel;
            int v = $urandom_range(0, 2);
            if (kind == 1 || kind == 2) a = a & ~32'(nBytes(sz) - 1);
            if (kind == 0) begin
                lsel = (v == 0) ? 2'b00 : 2'(v + 1);
                applyStimulus(0, 0, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                              $urandom, lsel, 1'($urandom_range(0, 1)), 5'($urandom),
                              $urandom, 0);
            end else begin
                if (kind == 1) rw = 1'b0;
                if (kind == 2) rw = 1'b1;
                lsel = rw ? 2'b00 : 2'b01;
                applyStimulus(1, rw, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                              $urandom, lsel, 1'($urandom_range(0, 1)), 5'($urandom),
                              $urandom, $urandom_range(0, 3));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_stage_access.md
MEM_STAGE_ACCESS -- requirements
Module: mem_stage_access

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port R, input, 1, asynchronous active-low reset (R=0 resets immediately, independent of clk).
REQ-003 SHALL have inputs E_mem 1, rw_dm_mem 1 (1=store), size_mem 2 (00 byte, 01 half, 1x word), se_mem 1 (sign-extend loads), all from EX/MEM.
REQ-004 SHALL have inputs alu_out_mem 32 (address/ALU result), store_data_mem 32, PC_D_mem 32, mem_sethi_imm22 32, all from EX/MEM.
REQ-005 SHALL have inputs load_mem 2 (writeback source: 00 ALU, 01 memory, 10 PC_D, 11 sethi), rf_le_mem 1, mem_rd 5, all from EX/MEM.
REQ-006 SHALL have memory outputs dm_req 1, dm_we 1, dm_addr 32, dm_wdata 32, dm_be 4, and memory inputs dm_rdata 32, dm_ack 1.
REQ-007 SHALL have outputs mem_stall 1 (freeze PC/IF/ID/EX/MEM), mem_fwd_data 32 (MEM-stage forward value), align_err 1.
REQ-008 SHALL have MEM/WB register outputs wb_data 32, wb_rd 5, wb_rf_le 1.

Function
REQ-009 SHALL implement FSM states IDLE and WAIT.
REQ-010 Access valid SHALL be E_mem=1 and address aligned: byte any, half alu_out_mem[0]=0, word alu_out_mem[1:0]=00.
REQ-011 IDLE with valid access: mem_stall=1 combinationally; next edge latch address, wdata, be, we, size, se, rd, rf_le into hold registers; go to WAIT.
REQ-012 WAIT: dm_req=1, dm_addr/dm_we/dm_wdata/dm_be from hold registers, stable until ack; mem_stall = ~dm_ack.
REQ-013 WAIT with dm_ack=1: mem_stall=0; at that edge MEM/WB captures the result and FSM returns to IDLE; minimum access = 2 cycles (1 stall cycle).
REQ-014 dm_req SHALL be 0 in IDLE; no new request SHALL issue in the cycle of ack return.
REQ-015 Byte lanes SHALL be big-endian: addr[1:0]=00 -> bits 31:24, 11 -> bits 7:0; half addr[1]=0 -> bits 31:16.
REQ-016 dm_be: byte one-hot per REQ-015 (00 -> 4'b1000), half 4'b1100/4'b0011, word 4'b1111; dm_wdata replicates store byte/half across all lanes.
REQ-017 Load data SHALL be extracted from the selected lane, sign-extended if se=1 else zero-extended to 32 bits.
REQ-018 Writeback value SHALL be mux by load_mem: ALU, extracted load data, PC_D_mem, mem_sethi_imm22.
REQ-019 Non-memory instruction (E_mem=0): mem_stall=0, MEM/WB loads mux value, rf_le_mem, mem_rd every cycle.
REQ-020 mem_fwd_data SHALL equal the REQ-018 mux value for the instruction currently in MEM (load data valid only in ack cycle).
REQ-021 While mem_stall=1, MEM/WB SHALL load a bubble (wb_rf_le=0, wb_rd=0, wb_data=0).
REQ-022 Store SHALL never write the register file: wb_rf_le=0 regardless of rf_le_mem.
REQ-023 Misaligned access with E_mem=1: no request, mem_stall=0, align_err=1 for that cycle, MEM/WB loads bubble.
REQ-024 dm_ack in IDLE SHALL be ignored.

Reset
REQ-025 R=0 SHALL force IDLE, dm_req=0, dm_we=0, dm_be=0, dm_addr=0, dm_wdata=0, align_err=0, wb_data=0, wb_rd=0, wb_rf_le=0, hold registers 0, asynchronously.
REQ-026 Reset during WAIT SHALL abandon the access; after release, late dm_ack SHALL be ignored per REQ-024.
REQ-027 mem_stall SHALL be 0 while R=0.

Verification
REQ-028 ALU op: E_mem=0, load_mem=00, alu_out_mem=0x12345678, mem_rd=5, rf_le_mem=1 -> next edge wb_data=0x12345678, wb_rd=5, wb_rf_le=1, mem_stall never 1.
REQ-029 Signed byte load: addr 0x101, size 00, se=1, dm_rdata=0x11F02233, ack 3 cycles after issue -> dm_be=4'b0100, mem_stall high 3 cycles, then wb_data=0xFFFFFFF0.
REQ-030 Half store: addr 0x202, size 01, store_data_mem=0x0000BEEF, immediate ack -> dm_we=1, dm_be=4'b0011, dm_wdata=0xBEEFBEEF, one stall cycle, wb_rf_le=0.
REQ-031 Misaligned word load at 0x103 -> dm_req stays 0, align_err=1 one cycle, wb_rf_le=0, no stall.
REQ-032 Reset mid-WAIT: R=0 with dm_req=1 -> dm_req=0 and wb outputs 0 immediately; dm_ack=1 after release -> no writeback, no stall.
REQ-033 Back-to-back loads word 0x0 then 0x4, ack immediate -> two distinct requests, each 1 stall cycle, wb_data follows in issue order.
